// File: rtl/mp_addsub_seq_pkg.sv
// Shared types and constants for the multi-word add/subtract sequencer.
package mp_addsub_seq_pkg;

    // Width of one adder slice; the slice is hard-wired to this width.
    localparam int unsigned W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Width of the word index for a given number of words (at least one bit).
    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/mp_addsub_seq_if.sv
// Request/result handshake bundle between requester and the add/sub sequencer.
interface mp_addsub_seq_if
    import mp_addsub_seq_pkg::*;
#(
    parameter int unsigned WORDS = 4
);
    localparam int unsigned N = W * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         busy;

    modport slave (
        input  in_valid, op_sub, a, b, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero, busy
    );

    modport master (
        output in_valid, op_sub, a, b, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero, busy
    );

endinterface

// File: rtl/add16_slice.sv
// One W-bit carry-lookahead adder slice: 4-bit groups with group-level lookahead.
module add16_slice
    import mp_addsub_seq_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         msb_cin
);
    localparam int unsigned G  = 4;
    localparam int unsigned NG = W / G;

    logic [W-1:0]  g;
    logic [W-1:0]  p;
    logic [W-1:0]  c;
    logic [NG-1:0] gg;
    logic [NG-1:0] pg;
    logic [NG:0]   cg;
    logic          carry;

    // Bit and group generate/propagate, group carries, then carries inside each group.
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        gg    = '0;
        pg    = '0;
        cg    = '0;
        c     = '0;
        carry = 1'b0;
        for (int j = 0; j < int'(NG); j++) begin
            gg[j] = g[j*G+3]
                  | (p[j*G+3] & g[j*G+2])
                  | (p[j*G+3] & p[j*G+2] & g[j*G+1])
                  | (p[j*G+3] & p[j*G+2] & p[j*G+1] & g[j*G]);
            pg[j] = &p[j*G +: G];
        end
        cg[0] = cin;
        for (int j = 0; j < int'(NG); j++) begin
            cg[j+1] = gg[j] | (pg[j] & cg[j]);
        end
        for (int j = 0; j < int'(NG); j++) begin
            carry = cg[j];
            for (int k = 0; k < int'(G); k++) begin
                c[j*G+k] = carry;
                carry    = g[j*G+k] | (p[j*G+k] & carry);
            end
        end
        sum     = p ^ c;
        cout    = cg[NG];
        msb_cin = c[W-1];
    end

endmodule

// File: rtl/mp_addsub_seq.sv
// Sequencer running a WORDS*W-bit add/subtract through one W-bit slice, LSW first.
module mp_addsub_seq
    import mp_addsub_seq_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mp_addsub_seq_if.slave  bus
);
    localparam int unsigned   N       = W * WORDS;
    localparam int unsigned   IW      = idx_width(WORDS);
    localparam logic [IW-1:0] LastIdx = IW'(WORDS - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          zero_q, zero_d;

    logic          in_ready;
    logic          accept;
    logic [W-1:0]  slice_a;
    logic [W-1:0]  slice_b;
    logic [W-1:0]  slice_sum;
    logic          slice_cout;
    logic          slice_msb_cin;
    logic [N-1:0]  result_upd;

    assign in_ready = (state_q == StIdle) | ((state_q == StDone) & bus.out_ready);
    assign accept   = bus.in_valid & in_ready;
    assign slice_a  = a_q[idx_q*W +: W];
    assign slice_b  = b_q[idx_q*W +: W];

    add16_slice u_slice (
        .a       (slice_a),
        .b       (slice_b),
        .cin     (carry_q),
        .sum     (slice_sum),
        .cout    (slice_cout),
        .msb_cin (slice_msb_cin)
    );

    // Next-state: word stepping in RUN, completion flags at the last word, accept loads.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        result_upd = result_q;
        result_upd[idx_q*W +: W] = slice_sum;

        unique case (state_q)
            StIdle: ;
            StRun: begin
                result_d = result_upd;
                carry_d  = slice_cout;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    idx_d   = '0;
                    cout_d  = slice_cout;
                    ovf_d   = slice_msb_cin ^ slice_cout;
                    zero_d  = (result_upd == '0);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Accept only happens in IDLE or in DONE while the result is taken.
        if (accept) begin
            state_d = StRun;
            idx_d   = '0;
            a_d     = bus.a;
            b_d     = bus.op_sub ? ~bus.b : bus.b;
            carry_d = bus.op_sub;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q == StRun);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Bench for mp_addsub_seq: directed corner cases plus randomized ops against an arithmetic model.
module tb_mp_addsub_seq;
    import mp_addsub_seq_pkg::*;

    localparam int unsigned WORDS = 4;
    localparam int unsigned N     = W * WORDS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mp_addsub_seq_if #(.WORDS(WORDS)) bus ();

    mp_addsub_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Plain N-bit arithmetic: unsigned for result/carry, signed widening for overflow.
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                                  output logic [N-1:0] r, output logic co, output logic ov,
                                  output logic zr);
        logic signed [N:0] sa;
        logic signed [N:0] sb;
        logic signed [N:0] sfull;
        logic [N:0]        ufull;
        sa = $signed({a[N-1], a});
        sb = $signed({b[N-1], b});
        if (sub) begin
            sfull = sa - sb;
            r     = a - b;
            co    = (a >= b);
        end else begin
            sfull = sa + sb;
            ufull = {1'b0, a} + {1'b0, b};
            r     = ufull[N-1:0];
            co    = ufull[N];
        end
        ov = (sfull[N] != sfull[N-1]);
        zr = (r == '0);
    endfunction

    // Called just after a negedge: present a request and let the next posedge accept it.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                            output bit ok);
        int n;
        bus.a        = a;
        bus.b        = b;
        bus.op_sub   = sub;
        bus.in_valid = 1'b1;
        n  = 0;
        ok = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
            ok = 1'b0;
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    // Counts cycles after the accept edge until out_valid is seen at a negedge.
    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat++;
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: out_valid=%b required 1 within 40 cycles", bus.out_valid);
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
        checks++;
        if (bus.result !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0 || bus.zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: result=%h cout=%b ovf=%b zero=%b required all 0",
                     bus.result, bus.cout, bus.ovf, bus.zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [N-1:0] ta [4];
        logic [N-1:0] tb [4];
        logic         ts [4];
        logic [N-1:0] er;
        logic         ec, eo, ez;
        int           lat;
        bit           ok;
        ta[0] = 64'h0000_0000_0000_0001; tb[0] = 64'hFFFF_FFFF_FFFF_FFFF; ts[0] = 1'b0;
        ta[1] = 64'h0000_0000_0001_0000; tb[1] = 64'h0000_0000_0000_0001; ts[1] = 1'b1;
        ta[2] = 64'h7FFF_FFFF_FFFF_FFFF; tb[2] = 64'h0000_0000_0000_0001; ts[2] = 1'b0;
        ta[3] = 64'h0000_0000_0000_0000; tb[3] = 64'h0000_0000_0000_0001; ts[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            model(ta[i], tb[i], ts[i], er, ec, eo, ez);
            start_op(ta[i], tb[i], ts[i], ok);
            if (!ok) continue;
            wait_done(lat, ok);
            if (!ok) continue;
            checks++;
            if (lat != int'(WORDS) + 1) begin
                failures++;
                $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, WORDS + 1);
            end
            checks++;
            if (bus.result !== er || bus.cout !== ec || bus.ovf !== eo || bus.zero !== ez) begin
                failures++;
                $display("FAIL dir%0d_result: got %h c%b v%b z%b required %h c%b v%b z%b", i,
                         bus.result, bus.cout, bus.ovf, bus.zero, er, ec, eo, ez);
            end
            consume();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL dir%0d_release: out_valid=%b in_ready=%b required 0 1", i,
                         bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_idle_out_ready();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL idle_out_ready: out_valid=%b busy=%b required 0 0",
                         bus.out_valid, bus.busy);
            end
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a1, b1, a2, b2, er, er2;
        logic         ec, eo, ez, ec2, eo2, ez2;
        int           lat;
        bit           ok;
        a1 = {$urandom, $urandom};
        b1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom};
        b2 = {$urandom, $urandom};
        model(a1, b1, 1'b1, er, ec, eo, ez);
        model(a2, b2, 1'b0, er2, ec2, eo2, ez2);
        start_op(a1, b1, 1'b1, ok);
        if (!ok) return;
        wait_done(lat, ok);
        if (!ok) return;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.result !== er || bus.cout !== ec ||
                bus.ovf !== eo || bus.zero !== ez) begin
                failures++;
                $display("FAIL hold_cycle%0d: v%b %h c%b o%b z%b required v1 %h c%b o%b z%b", i,
                         bus.out_valid, bus.result, bus.cout, bus.ovf, bus.zero, er, ec, eo, ez);
            end
            @(negedge clk);
        end
        bus.a         = a2;
        bus.b         = b2;
        bus.op_sub    = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_in_ready: got %b required 1", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_bubble: busy=%b out_valid=%b required 1 0",
                     bus.busy, bus.out_valid);
        end
        wait_done(lat, ok);
        if (!ok) return;
        checks++;
        if (lat != int'(WORDS)) begin
            failures++;
            $display("FAIL b2b_latency: got %0d required %0d", lat + 1, WORDS + 1);
        end
        checks++;
        if (bus.result !== er2 || bus.cout !== ec2 || bus.ovf !== eo2 || bus.zero !== ez2) begin
            failures++;
            $display("FAIL b2b_result: got %h c%b v%b z%b required %h c%b v%b z%b",
                     bus.result, bus.cout, bus.ovf, bus.zero, er2, ec2, eo2, ez2);
        end
        consume();
    endtask

    task automatic test_reset_mid_run();
        logic [N-1:0] er;
        logic         ec, eo, ez;
        int           lat;
        bit           ok;
        start_op(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b0, ok);
        if (!ok) return;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.result !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0 || bus.zero !== 1'b0 ||
            bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrun_reset: r=%h c%b o%b z%b busy%b v%b rdy%b required 0s rdy1",
                     bus.result, bus.cout, bus.ovf, bus.zero, bus.busy, bus.out_valid,
                     bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL midrun_discard: out_valid=%b in_ready=%b required 0 1",
                         bus.out_valid, bus.in_ready);
            end
        end
        model(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, er, ec, eo, ez);
        start_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, ok);
        if (!ok) return;
        wait_done(lat, ok);
        if (!ok) return;
        checks++;
        if (bus.result !== er || bus.cout !== ec || bus.ovf !== eo || bus.zero !== ez ||
            lat != int'(WORDS) + 1) begin
            failures++;
            $display("FAIL post_reset_op: got %h c%b v%b z%b lat%0d required %h c%b v%b z%b lat%0d",
                     bus.result, bus.cout, bus.ovf, bus.zero, lat, er, ec, eo, ez, WORDS + 1);
        end
        consume();
    endtask

    task automatic test_random();
        logic [N-1:0] a, b, er;
        logic         s, ec, eo, ez;
        int           lat;
        bit           ok;
        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = '1;
                2: a = {1'b0, {(N-1){1'b1}}};
                default: ;
            endcase
            s = 1'($urandom_range(0, 1));
            model(a, b, s, er, ec, eo, ez);
            start_op(a, b, s, ok);
            if (!ok) continue;
            wait_done(lat, ok);
            if (!ok) continue;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if (bus.result !== er || bus.cout !== ec || bus.ovf !== eo || bus.zero !== ez ||
                lat != int'(WORDS) + 1) begin
                failures++;
                $display("FAIL rand%0d: got %h c%b v%b z%b lat%0d required %h c%b v%b z%b lat%0d",
                         i, bus.result, bus.cout, bus.ovf, bus.zero, lat, er, ec, eo, ez,
                         WORDS + 1);
            end
            consume();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_sub    = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        test_reset();
        test_directed();
        test_idle_out_ready();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
